// File: rtl/buffer_pingpong_ctrl_pkg.sv
// Shared definitions for the ping-pong buffer controller.
//   bank_state_e : per-bank occupancy state (EMPTY -> SETTLE -> FULL -> EMPTY)
//   NUM_BANKS    : number of buffers handled by the controller
package buffer_pingpong_ctrl_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY  = 2'd0,
    BANK_SETTLE = 2'd1,
    BANK_FULL   = 2'd2
  } bank_state_e;

  localparam int unsigned NUM_BANKS = 2;

endpackage

// File: rtl/buffer_pingpong_ctrl_wrap_counter.sv
// Enabled up-counter that wraps to zero after reaching MAX.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   en_i     : advance the count this cycle
//   cnt_o    : current count, 0..MAX
//   wrap_o   : en_i while count == MAX (count returns to 0 on this edge)
module pp_wrap_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             at_max;

  always_comb begin
    at_max = (cnt_q == MAX_V);
    cnt_d  = cnt_q;
    if (en_i) begin
      cnt_d = at_max ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i & at_max;

endmodule

// File: rtl/buffer_pingpong_ctrl.sv
// Ping-pong controller for two word buffers (registered write, combinational
// read). The producer fills one bank while the consumer sweeps the other bank
// PASSES times; a bank is only reopened for writing once its last pass ends.
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid / in_ready  : producer handshake; buf_we/buf_wa drive the banks
//   buf_ra, rd_bank      : read address and bank select for the consumer
//   out_valid/out_ready  : consumer handshake; out_first/out_last mark addr 0
//                          and WORD_NUM-1 of each pass, pass_idx = pass number
//   frame_done           : registered pulse after a bank is released
//   bank_full            : bit b set while bank b is FULL
module buffer_pingpong_ctrl
  import buffer_pingpong_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WORD_NUM   = 196,
  parameter int unsigned PASSES     = 1,
  parameter int unsigned PASS_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [1:0]            buf_we,
  output logic [ADDR_WIDTH-1:0] buf_wa,
  output logic [ADDR_WIDTH-1:0] buf_ra,
  output logic                  rd_bank,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last,
  output logic [PASS_WIDTH-1:0] pass_idx,
  output logic                  frame_done,
  output logic [1:0]            bank_full
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_NUM - 1);

  bank_state_e state_q [NUM_BANKS];
  bank_state_e state_d [NUM_BANKS];
  logic        wbank_q, wbank_d;
  logic        rbank_q, rbank_d;
  logic        frame_done_q, frame_done_d;

  logic                  accept, take;
  logic                  wwrap, rwrap, pwrap;
  logic [ADDR_WIDTH-1:0] wcnt, rcnt;
  logic [PASS_WIDTH-1:0] pass_cnt;

  // Write side
  assign in_ready = (state_q[wbank_q] == BANK_EMPTY) & ~reset;
  assign accept   = in_valid & in_ready;

  pp_wrap_counter #(.WIDTH(ADDR_WIDTH), .MAX(WORD_NUM - 1)) u_wcnt (
    .clk    (clk),
    .rst    (reset),
    .en_i   (accept),
    .cnt_o  (wcnt),
    .wrap_o (wwrap)
  );

  // Read side
  assign out_valid = (state_q[rbank_q] == BANK_FULL) & ~reset;
  assign take      = out_valid & out_ready;

  pp_wrap_counter #(.WIDTH(ADDR_WIDTH), .MAX(WORD_NUM - 1)) u_rcnt (
    .clk    (clk),
    .rst    (reset),
    .en_i   (take),
    .cnt_o  (rcnt),
    .wrap_o (rwrap)
  );

  // pwrap marks the final word of the final pass: the read bank is released
  pp_wrap_counter #(.WIDTH(PASS_WIDTH), .MAX(PASSES - 1)) u_pass (
    .clk    (clk),
    .rst    (reset),
    .en_i   (rwrap),
    .cnt_o  (pass_cnt),
    .wrap_o (pwrap)
  );

  // A bank cannot be completed by the writer and released by the reader on
  // the same edge (EMPTY vs FULL), so both updates can be applied independently.
  always_comb begin
    wbank_d      = wbank_q ^ wwrap;
    rbank_d      = rbank_q ^ pwrap;
    frame_done_d = pwrap;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      state_d[b] = state_q[b];
      if (state_q[b] == BANK_SETTLE) state_d[b] = BANK_FULL;
      if (wwrap && (wbank_q == b[0])) state_d[b] = BANK_SETTLE;
      if (pwrap && (rbank_q == b[0])) state_d[b] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= BANK_EMPTY;
      end
      wbank_q      <= 1'b0;
      rbank_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= state_d[b];
      end
      wbank_q      <= wbank_d;
      rbank_q      <= rbank_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    buf_we          = '0;
    buf_we[wbank_q] = accept;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_full[b] = (state_q[b] == BANK_FULL);
    end
  end

  assign buf_wa     = wcnt;
  assign buf_ra     = rcnt;
  assign rd_bank    = rbank_q;
  assign out_first  = out_valid & (rcnt == '0);
  assign out_last   = out_valid & (rcnt == LAST_ADDR);
  assign pass_idx   = pass_cnt;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_buffer_pingpong_ctrl.sv
module tb_buffer_pingpong_ctrl;

  localparam int W  = 4;
  localparam int P  = 2;
  localparam int BW = 196;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance: WORD_NUM=4, PASSES=2
  logic       rst, iv, ird, rb, ov, ordy, of, ol, fd;
  logic [1:0] we, bf;
  logic [7:0] wa, ra, din;
  logic [3:0] pi;

  buffer_pingpong_ctrl #(.ADDR_WIDTH(8), .WORD_NUM(W), .PASSES(P), .PASS_WIDTH(4)) dut (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ird), .buf_we(we), .buf_wa(wa),
    .buf_ra(ra), .rd_bank(rb), .out_valid(ov), .out_ready(ordy), .out_first(of),
    .out_last(ol), .pass_idx(pi), .frame_done(fd), .bank_full(bf)
  );

  // default instance: WORD_NUM=196, PASSES=1
  logic        b_rst, b_iv, b_ird, b_rb, b_ov, b_ordy, b_of, b_ol, b_fd;
  logic [1:0]  b_we, b_bf;
  logic [7:0]  b_wa, b_ra;
  logic [3:0]  b_pi;
  logic [15:0] b_din;

  buffer_pingpong_ctrl u_big (
    .clk(clk), .reset(b_rst), .in_valid(b_iv), .in_ready(b_ird), .buf_we(b_we), .buf_wa(b_wa),
    .buf_ra(b_ra), .rd_bank(b_rb), .out_valid(b_ov), .out_ready(b_ordy), .out_first(b_of),
    .out_last(b_ol), .pass_idx(b_pi), .frame_done(b_fd), .bank_full(b_bf)
  );

  // buffer models (registered write)
  logic [7:0]  mem_s [2][W];
  logic [15:0] mem_b [2][BW];
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (we[b])   mem_s[b][wa[1:0]] <= din;
      if (b_we[b]) mem_b[b][b_wa]    <= b_din;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // scoreboard state
  typedef struct {
    logic [7:0] data;
    logic [7:0] addr;
    logic [3:0] pass;
    logic       first;
    logic       last;
    logic       bank;
  } rec_t;
  rec_t       exp_q[$];
  logic [7:0] wframe[$];
  int         fidx, takes, fd_cnt, cyc;
  logic       fd_exp, stall_v;
  logic [7:0] stall_ra;
  logic [3:0] stall_pass;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  addr;
  } brec_t;
  brec_t bq[$];
  int    b_acc, b_takes, b_first_cyc, b_last_cyc;

  task automatic monitor();
    rec_t  e;
    brec_t be;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete(); wframe.delete();
        fidx = 0; takes = 0; fd_cnt = 0; fd_exp = 1'b0; stall_v = 1'b0;
      end else begin
        if (fd_exp || fd) check("frame_done", fd, fd_exp);
        if (fd) fd_cnt++;
        fd_exp = 1'b0;
        if (stall_v) begin
          check("stall_ra", ra, stall_ra);
          check("stall_pass", pi, stall_pass);
          check("stall_valid", ov, 1);
        end
        stall_v = ov && !ordy; stall_ra = ra; stall_pass = pi;
        if (iv && ird) begin
          wframe.push_back(din);
          if (wframe.size() == W) begin
            for (int p = 0; p < P; p++)
              for (int a = 0; a < W; a++) begin
                e.data = wframe[a]; e.addr = 8'(a); e.pass = 4'(p);
                e.first = (a == 0); e.last = (a == W - 1); e.bank = fidx[0];
                exp_q.push_back(e);
              end
            fidx++;
            wframe.delete();
          end
        end
        if (ov && ordy) begin
          takes++;
          if (exp_q.size() == 0) check("unexpected_read", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("rdata", mem_s[rb][ra[1:0]], e.data);
            check("buf_ra", ra, e.addr);
            check("pass_idx", pi, e.pass);
            check("out_first", of, e.first);
            check("out_last", ol, e.last);
            check("rd_bank", rb, e.bank);
            if (e.last && e.pass == 4'(P - 1)) fd_exp = 1'b1;
          end
        end
      end
      if (b_rst) begin
        bq.delete(); b_acc = 0; b_takes = 0;
      end else begin
        if (b_iv && b_ird) begin
          be.data = b_din; be.addr = 8'(b_acc % BW);
          bq.push_back(be); b_acc++;
        end
        if (b_ov && b_ordy) begin
          if (b_takes == 0) b_first_cyc = cyc;
          b_last_cyc = cyc;
          b_takes++;
          if (bq.size() == 0) check("big_unexpected_read", 1, 0);
          else begin
            be = bq.pop_front();
            check("big_rdata", mem_b[b_rb][b_ra], be.data);
            check("big_buf_ra", b_ra, be.addr);
          end
        end
      end
    end
  endtask

  // table for the basic frame
  typedef struct {
    logic iv; logic [7:0] din; logic ordy;
    logic ird; logic [1:0] we; logic [7:0] wa; logic ov; logic [7:0] ra;
    logic first; logic last; logic [3:0] pass; logic [1:0] full; logic fd; logic [7:0] rdata;
  } vec_t;
  vec_t tv[15];

  function automatic vec_t mk(logic i_v, logic [7:0] d, logic o_r, logic e_ird, logic [1:0] e_we,
                              logic [7:0] e_wa, logic e_ov, logic [7:0] e_ra, logic e_f, logic e_l,
                              logic [3:0] e_p, logic [1:0] e_full, logic e_fd, logic [7:0] e_rd);
    vec_t v;
    v.iv = i_v; v.din = d; v.ordy = o_r; v.ird = e_ird; v.we = e_we; v.wa = e_wa; v.ov = e_ov;
    v.ra = e_ra; v.first = e_f; v.last = e_l; v.pass = e_p; v.full = e_full; v.fd = e_fd;
    v.rdata = e_rd;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; iv = 1'b0; ordy = 1'b0; din = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_rst_outputs();
    check("rst_in_ready", ird, 0);
    check("rst_buf_we", we, 0);
    check("rst_buf_wa", wa, 0);
    check("rst_out_valid", ov, 0);
    check("rst_buf_ra", ra, 0);
    check("rst_rd_bank", rb, 0);
    check("rst_pass_idx", pi, 0);
    check("rst_first_last", {of, ol}, 0);
    check("rst_frame_done", fd, 0);
    check("rst_bank_full", bf, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, bsent;
    rst = 1'b1; iv = 1'b0; ordy = 1'b0; din = '0;
    b_rst = 1'b1; b_iv = 1'b0; b_ordy = 1'b0; b_din = '0;
    fork monitor(); join_none

    // Test 1: table-driven basic frame
    for (int i = 0; i < 4; i++)
      tv[i] = mk(1, 8'h10 + 8'(i), 0, 1, 2'b01, 8'(i), 0, 0, 0, 0, 0, 2'b00, 0, 0);
    tv[4] = mk(0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 4; a++)
        tv[5 + p * 4 + a] = mk(0, 0, 1, 1, 2'b00, 0, 1, 8'(a), a == 0, a == 3, 4'(p), 2'b01, 0,
                               8'h10 + 8'(a));
    tv[13] = mk(0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    tv[14] = mk(0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

    rst = 1'b1; #1;
    check_rst_outputs();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      iv = tv[i].iv; din = tv[i].din; ordy = tv[i].ordy;
      @(negedge clk);
      check("t1_in_ready", ird, tv[i].ird);
      check("t1_buf_we", we, tv[i].we);
      check("t1_buf_wa", wa, tv[i].wa);
      check("t1_out_valid", ov, tv[i].ov);
      check("t1_buf_ra", ra, tv[i].ra);
      check("t1_first", of, tv[i].first);
      check("t1_last", ol, tv[i].last);
      check("t1_pass", pi, tv[i].pass);
      check("t1_bank_full", bf, tv[i].full);
      check("t1_frame_done", fd, tv[i].fd);
      if (tv[i].ov) check("t1_rdata", mem_s[rb][ra[1:0]], tv[i].rdata);
      @(posedge clk); #1;
    end

    // Test 2: continuous input, 3 frames
    do_reset();
    sent = 0;
    for (int c = 0; c < 80 && takes < 24; c++) begin
      iv = (sent < 12); din = 8'h20 + 8'(sent); ordy = 1'b1;
      @(negedge clk);
      if (bf == 2'b11) check("t2_blocked", ird, 0);
      if (iv && ird) sent++;
      @(posedge clk); #1;
    end
    iv = 1'b0;
    @(negedge clk);
    check("t2_sent", sent, 12);
    check("t2_takes", takes, 24);
    check("t2_frames", fd_cnt, 3);
    @(posedge clk); #1;

    // Test 3: random consumer stalls
    do_reset();
    sent = 0;
    for (int c = 0; c < 300 && takes < 16; c++) begin
      iv = (sent < 8); din = 8'h30 + 8'(sent); ordy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (iv && ird) sent++;
      @(posedge clk); #1;
    end
    ordy = 1'b0; iv = 1'b0;
    @(negedge clk);
    check("t3_takes", takes, 16);
    @(posedge clk); #1;

    // Test 4: writer completes bank 1 on the edge reader releases bank 0
    do_reset();
    for (int c = 0; c < 15; c++) begin
      iv = (c < 4) || (c >= 9 && c <= 12);
      din = 8'h40 + 8'(c);
      ordy = 1'b1;
      @(negedge clk);
      if (c == 12) begin
        check("t4_c12_we", we, 2'b10);
        check("t4_c12_wa", wa, 3);
        check("t4_c12_last", {ol, pi}, {1'b1, 4'd1});
      end
      if (c == 13) begin
        check("t4_c13_in_ready", ird, 1);
        check("t4_c13_frame_done", fd, 1);
        check("t4_c13_bank_full", bf, 2'b00);
        check("t4_c13_out_valid", ov, 0);
        check("t4_c13_rd_bank", rb, 1);
      end
      if (c == 14) begin
        check("t4_c14_bank_full", bf, 2'b10);
        check("t4_c14_out_valid", ov, 1);
      end
      @(posedge clk); #1;
    end
    iv = 1'b1; din = 8'h4F;
    @(negedge clk);
    check("t4_wbank0_we", we, 2'b01);
    @(posedge clk); #1;

    // Test 5: reset mid-frame and mid-pass
    do_reset();
    for (int c = 0; c < 7; c++) begin
      iv = (c < 6); din = 8'h50 + 8'(c); ordy = (c >= 5);
      @(negedge clk);
      @(posedge clk); #1;
    end
    rst = 1'b1; iv = 1'b0; ordy = 1'b0;
    #1;
    check_rst_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      iv = (c < 4); din = 8'hA0 + 8'(c); ordy = 1'b1;
      @(negedge clk);
      if (c == 0) check("t5_restart_we_wa", {we, wa}, {2'b01, 8'd0});
      @(posedge clk); #1;
    end
    iv = 1'b0; ordy = 1'b0;
    @(negedge clk);
    check("t5_takes", takes, 8);
    check("t5_frames", fd_cnt, 1);
    @(posedge clk); #1;

    // Test 6: default parameters, 3 frames of 196 words
    b_rst = 1'b0;
    bsent = 0;
    for (int c = 0; c < 1500 && b_takes < 3 * BW; c++) begin
      b_iv = (bsent < 3 * BW);
      b_din = {8'(bsent / BW), 8'(bsent % BW)};
      b_ordy = 1'b1;
      @(negedge clk);
      if (b_iv && b_ird) bsent++;
      @(posedge clk); #1;
    end
    b_iv = 1'b0;
    @(negedge clk);
    check("t6_takes", b_takes, 3 * BW);
    check("t6_rate", (b_last_cyc - b_first_cyc) <= 3 * BW + 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
